// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the instruction/data memory arbiter.
// Widths are also used by the memory array and the control unit.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_USR = 1'b0,
    OWN_CU  = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the low-priority requester.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   inc           low-priority requester was pending and lost this arbitration
//   clr           restart the count (low side won / idle / priority flipped)
//   force_low     registered flag: count has reached LIMIT
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic force_low
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  // clr and inc together restart the count at one, so a loss in the same
  // cycle as a priority flip is still counted under the new meaning.
  always_comb begin
    cnt_d = clr ? '0 : cnt;
    if (inc && (cnt_d != CW'(LIMIT))) begin
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      force_low <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      force_low <= (cnt_d == CW'(LIMIT));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (user loader port, control unit) in front of the
// single-port synchronous instruction/data memory.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   op                      1: control unit has priority, 0: user has priority
//   usr_* / cu_*            req/we/addr/wdata in, gnt/rvalid/rdata out
//   mem_en/mem_we/mem_addr/mem_wdata   memory strobe and command
//   mem_rdata               memory read data, one cycle after the strobe
//   busy                    high whenever not IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op,
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_gnt,
  output logic              usr_rvalid,
  output logic [DATA_W-1:0] usr_rdata,
  input  logic              cu_req,
  input  logic              cu_we,
  input  logic [ADDR_W-1:0] cu_addr,
  input  logic [DATA_W-1:0] cu_wdata,
  output logic              cu_gnt,
  output logic              cu_rvalid,
  output logic [DATA_W-1:0] cu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic   we_q, we_d;
  logic   op_q;

  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              usr_gnt_d, cu_gnt_d, usr_rvalid_d, cu_rvalid_d;
  logic [DATA_W-1:0] usr_rdata_d, cu_rdata_d;
  logic              busy_d;

  logic op_chg, hi_req, lo_req, pick_low, win_cu;
  logic starve_inc, starve_clr, force_low;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inc       (starve_inc),
    .clr       (starve_clr),
    .force_low (force_low)
  );

  // Next-state, arbitration and registered-output values.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    usr_gnt_d    = 1'b0;
    cu_gnt_d     = 1'b0;
    usr_rvalid_d = 1'b0;
    cu_rvalid_d  = 1'b0;
    usr_rdata_d  = usr_rdata;
    cu_rdata_d   = cu_rdata;
    starve_inc   = 1'b0;
    starve_clr   = 1'b0;

    // A flipped op invalidates the count, including the saturated flag.
    op_chg   = (op != op_q);
    hi_req   = op ? cu_req : usr_req;
    lo_req   = op ? usr_req : cu_req;
    pick_low = lo_req && (!hi_req || (force_low && !op_chg));
    win_cu   = op ^ pick_low;
    if (op_chg) begin
      starve_clr = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (usr_req || cu_req) begin
          state_d     = ACCESS;
          owner_d     = win_cu ? OWN_CU : OWN_USR;
          we_d        = win_cu ? cu_we : usr_we;
          mem_addr_d  = win_cu ? cu_addr : usr_addr;
          mem_wdata_d = win_cu ? cu_wdata : usr_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          usr_gnt_d   = !win_cu;
          cu_gnt_d    = win_cu;
        end
        if (lo_req && !pick_low) begin
          starve_inc = 1'b1;
        end else begin
          starve_clr = 1'b1;
        end
      end
      ACCESS: begin
        state_d = we_q ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
        if (owner_q == OWN_CU) begin
          cu_rdata_d  = mem_rdata;
          cu_rvalid_d = 1'b1;
        end else begin
          usr_rdata_d  = mem_rdata;
          usr_rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_USR;
      we_q       <= 1'b0;
      op_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      usr_gnt    <= 1'b0;
      cu_gnt     <= 1'b0;
      usr_rvalid <= 1'b0;
      cu_rvalid  <= 1'b0;
      usr_rdata  <= '0;
      cu_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      op_q       <= op;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      usr_gnt    <= usr_gnt_d;
      cu_gnt     <= cu_gnt_d;
      usr_rvalid <= usr_rvalid_d;
      cu_rvalid  <= cu_rvalid_d;
      usr_rdata  <= usr_rdata_d;
      cu_rdata   <= cu_rdata_d;
      busy       <= busy_d;
    end
  end

endmodule
